// File: rtl/iterative_rotator_pkg.sv
// Shared definitions for the multi-cycle right-direction shift unit:
// operation mode encodings and the controller state type.
package iterative_rotator_pkg;

    // Operation select captured with each accepted request
    localparam logic MODE_ROR = 1'b0;
    localparam logic MODE_SRL = 1'b1;

    // Controller states; the unused encoding 2'b11 falls back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } rot_state_e;

endpackage : iterative_rotator_pkg

// File: rtl/iterative_rotator.sv
// Iterative rotate-right / shift-right-logical unit.
// Moves the captured operand one bit position per clock, counting the
// captured amount down to zero, then pulses done for one cycle.
// The result stays in rot_out until the next accepted request.
// busy and done are registered from the next-state decode so that no
// output depends combinationally on any input.
module iterative_rotator
    import iterative_rotator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rot_in,
    input  logic [CNT_W-1:0] rot_val,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rot_out
);

    rot_state_e       state_r;
    rot_state_e       state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             mode_r;
    logic             mode_next_s;
    logic [WIDTH-1:0] data_next_s;

    // One-position right move; the vacated MSB takes the old LSB (ROR) or zero (SRL)
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic             m);
        logic [WIDTH-1:0] r;
        if (m == MODE_SRL) begin
            r = {1'b0, d[WIDTH-1:1]};
        end else begin
            r = {d[0], d[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Next-state, next-data and next-count decode for the three-state controller
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        mode_next_s  = mode_r;
        data_next_s  = rot_out;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    data_next_s  = rot_in;
                    count_next_s = rot_val;
                    mode_next_s  = mode;
                    if (rot_val == {CNT_W{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                // Requests and operand changes are ignored while shifting
                data_next_s  = shift_step(rot_out, mode_r);
                count_next_s = count_r - CNT_W'(1);
                if (count_r == CNT_W'(1)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs; reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
            mode_r  <= MODE_ROR;
            rot_out <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            mode_r  <= mode_next_s;
            rot_out <= data_next_s;
            busy    <= (state_next_s == SHIFT);
            done    <= (state_next_s == DONE);
        end
    end

endmodule : iterative_rotator

// File: tb/tb_iterative_rotator.sv
// Directed scoreboard bench for iterative_rotator.
// The stimulus side pushes the hand-computed result, the expected done
// cycle and the expected busy length; a forked monitor pops and compares
// every time done is seen.
module tb_iterative_rotator;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
        int               busy_n;
        string            name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] rot_in;
    logic [CNT_W-1:0] rot_val;
    logic             mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rot_out;

    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    iterative_rotator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rot_in  (rot_in),
        .rot_val (rot_val),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .rot_out (rot_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: counts busy cycles and checks each done against the scoreboard
    task automatic monitor_loop();
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_data"}, 32'(rot_out), 32'(e.data));
                    check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                    check({e.name, "_busy_len"}, 32'(busy_cnt), 32'(e.busy_n));
                    check({e.name, "_busy_in_done"}, 32'(busy), 32'd0);
                end
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    endtask

    // Issue one request from a negedge; optionally record its expected outcome
    task automatic launch(input string name, input logic m, input logic [WIDTH-1:0] d,
                          input int n, input logic [WIDTH-1:0] exp_d, input bit track);
        exp_t e;
        start   = 1'b1;
        mode    = m;
        rot_in  = d;
        rot_val = CNT_W'(n);
        if (track) begin
            e.data   = exp_d;
            e.cyc    = cyc + n + 1;
            e.busy_n = n;
            e.name   = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        rot_in  = 16'h0000;
        rot_val = 4'd0;
        mode    = 1'b0;
    endtask

    // Wait (bounded) until the negedge of a done cycle
    task automatic wait_done(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        rot_in  = 16'h0000;
        rot_val = 4'd0;
        mode    = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rot_out", 32'(rot_out), 32'h0);
        rst = 1'b0;

        @(negedge clk);
        launch("ror_8001_n1", 1'b0, 16'h8001, 1, 16'hC000, 1'b1);
        wait_done("ror_8001_n1");

        @(negedge clk);
        launch("ror_1234_n4", 1'b0, 16'h1234, 4, 16'h4123, 1'b1);
        wait_done("ror_1234_n4");

        @(negedge clk);
        launch("srl_8000_n15", 1'b1, 16'h8000, 15, 16'h0001, 1'b1);
        wait_done("srl_8000_n15");

        @(negedge clk);
        launch("ror_8000_n15", 1'b0, 16'h8000, 15, 16'h0001, 1'b1);
        wait_done("ror_8000_n15");

        @(negedge clk);
        launch("ror_0001_n15", 1'b0, 16'h0001, 15, 16'h0002, 1'b1);
        wait_done("ror_0001_n15");

        @(negedge clk);
        launch("ror_beef_n0", 1'b0, 16'hBEEF, 0, 16'hBEEF, 1'b1);
        wait_done("ror_beef_n0");

        @(negedge clk);
        launch("srl_beef_n0", 1'b1, 16'hBEEF, 0, 16'hBEEF, 1'b1);
        wait_done("srl_beef_n0");

        // Request during SHIFT must be ignored
        @(negedge clk);
        launch("ror_00ff_n8", 1'b0, 16'h00FF, 8, 16'hFF00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        rot_in  = 16'h1234;
        rot_val = 4'd3;
        mode    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        wait_done("ror_00ff_n8");
        // Back-to-back accept in the done cycle
        launch("srl_ffff_n2", 1'b1, 16'hFFFF, 2, 16'h3FFF, 1'b1);
        wait_done("srl_ffff_n2");

        // Reset mid-shift
        @(negedge clk);
        launch("srl_abort", 1'b1, 16'h8000, 15, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rot_out", 32'(rot_out), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_idle_busy", 32'(busy), 32'd0);
        launch("ror_0003_n1", 1'b0, 16'h0003, 1, 16'h8001, 1'b1);
        wait_done("ror_0003_n1");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_iterative_rotator
